// File: rtl/ioctl_loader.sv
// ioctl_loader: drives the ioctl download bus from a valid/ready byte stream.
// Ports: clk_sys, reset_n (sync, active-low); start/index_in begin a download;
//   s_data/s_valid/s_last/s_ready carry the image; ioctl_* go to the core's
//   loaders and ioctl_wait back-pressures them; busy/done/byte_count report
//   progress. Define IOCTL_LOADER_CSUM_EN to add the 8-bit checksum output.
module ioctl_loader #(
    parameter int WR_GAP = 3,
    parameter int ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        index_in,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count
`ifdef IOCTL_LOADER_CSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_WRITE,
        S_GAP,
        S_TAIL
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    // Last gap count; unreachable (and unused) when WR_GAP is zero.
    localparam logic [3:0]        GAP_END = 4'(WR_GAP - 1);

    state_t            state_q, state_d;
    logic [7:0]        index_q, index_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic [ADDR_W-1:0] next_q, next_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              last_q, last_d;
    logic [3:0]        gap_q, gap_d;
    logic              done_q, done_d;
`ifdef IOCTL_LOADER_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            next_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            gap_q   <= '0;
            done_q  <= 1'b0;
`ifdef IOCTL_LOADER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            next_q  <= next_d;
            count_q <= count_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
`ifdef IOCTL_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        next_d  = next_q;
        count_d = count_q;
        last_d  = last_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
`ifdef IOCTL_LOADER_CSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = index_in;
                    next_d  = '0;
                    count_d = '0;
`ifdef IOCTL_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_ARM;
                end
            end
            S_ARM: state_d = S_FETCH;
            S_FETCH: begin
                if (s_valid && !ioctl_wait) begin
                    addr_d  = next_q;
                    dout_d  = s_data;
                    next_d  = next_q + A_ONE;
                    last_d  = s_last;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q + A_ONE;
`ifdef IOCTL_LOADER_CSUM_EN
                csum_d  = csum_q + dout_q;
`endif
                gap_d   = '0;
                if (WR_GAP > 0)
                    state_d = S_GAP;
                else
                    state_d = last_q ? S_TAIL : S_FETCH;
            end
            S_GAP: begin
                if (gap_q == GAP_END)
                    state_d = last_q ? S_TAIL : S_FETCH;
                else
                    gap_d = gap_q + 4'd1;
            end
            S_TAIL: begin
                // done is registered so it rises together with the fall of
                // ioctl_download on the first IDLE cycle.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign ioctl_download = busy;
    assign ioctl_wr       = (state_q == S_WRITE);
    assign s_ready        = (state_q == S_FETCH) && !ioctl_wait;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
    assign byte_count     = count_q;
    assign done           = done_q;
`ifdef IOCTL_LOADER_CSUM_EN
    assign checksum       = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: two loaders (WR_GAP 0 and 3) checked every cycle against
// a timeline model, plus directed scenarios with literal expectations.
module tb_ioctl_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        start, s_valid, s_last, ioctl_wait;
    logic [7:0]        index_in [2];
    logic [7:0]        s_data [2];
    logic [1:0]        s_ready, dl, wr, busy, done;
    logic [24:0]       addr [2];
    logic [24:0]       bcnt [2];
    logic [7:0]        dout [2];
    logic [7:0]        idx [2];
`ifdef IOCTL_LOADER_CSUM_EN
    logic [7:0]        csum [2];
`endif

    ioctl_loader #(.WR_GAP(0), .ADDR_W(25)) u0 (
        .clk_sys(clk), .reset_n(reset_n), .start(start[0]),
        .index_in(index_in[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_ready(s_ready[0]), .ioctl_download(dl[0]),
        .ioctl_wr(wr[0]), .ioctl_addr(addr[0]), .ioctl_dout(dout[0]),
        .ioctl_index(idx[0]), .ioctl_wait(ioctl_wait[0]), .busy(busy[0]),
        .done(done[0]), .byte_count(bcnt[0])
`ifdef IOCTL_LOADER_CSUM_EN
        , .checksum(csum[0])
`endif
    );

    ioctl_loader #(.WR_GAP(3), .ADDR_W(25)) u1 (
        .clk_sys(clk), .reset_n(reset_n), .start(start[1]),
        .index_in(index_in[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_ready(s_ready[1]), .ioctl_download(dl[1]),
        .ioctl_wr(wr[1]), .ioctl_addr(addr[1]), .ioctl_dout(dout[1]),
        .ioctl_index(idx[1]), .ioctl_wait(ioctl_wait[1]), .busy(busy[1]),
        .done(done[1]), .byte_count(bcnt[1])
`ifdef IOCTL_LOADER_CSUM_EN
        , .checksum(csum[1])
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input int k, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL u%0d %s cycle %0d: got %h want %h",
                     k, nm, cyc, act, exp);
        end
    endtask

    // Timeline model: each instance is described by the cycles at which
    // it may accept, will write and will finish.
    bit          m_busy [2];
    bit          m_last [2];
    int          rdy_at [2];
    int          wr_at [2];
    int          done_at [2];
    logic [24:0] nxt [2];
    logic [24:0] p_addr [2];
    logic [24:0] m_addr [2];
    logic [24:0] m_cnt [2];
    logic [7:0]  p_dout [2];
    logic [7:0]  m_dout [2];
    logic [7:0]  m_idx [2];
    logic [7:0]  m_cs [2];

    // Observations of the DUT used by the literal checks.
    logic [24:0] lg_addr [2][300];
    logic [7:0]  lg_dout [2][300];
    int          nwr [2];
    int          last_wr [2];
    int          min_gap [2];
    int          ndone [2];
    int          done_cyc [2];

    task automatic clr_log(input int k);
        nwr[k] = 0;
        last_wr[k] = -1;
        min_gap[k] = 1000;
    endtask

    task automatic model_cycle(input int k);
        int g;
        bit e_rdy, e_wr, e_done;
        g = (k == 0) ? 0 : 3;
        if (cyc == wr_at[k]) begin
            m_addr[k] = p_addr[k];
            m_dout[k] = p_dout[k];
        end
        if (cyc == done_at[k]) m_busy[k] = 1'b0;
        e_wr   = (cyc == wr_at[k]);
        e_done = (cyc == done_at[k]);
        e_rdy  = m_busy[k] && !m_last[k] && cyc >= rdy_at[k] && !ioctl_wait[k];
        chk(k, "download", dl[k], m_busy[k]);
        chk(k, "busy", busy[k], m_busy[k]);
        chk(k, "wr", wr[k], e_wr);
        chk(k, "done", done[k], e_done);
        chk(k, "s_ready", s_ready[k], e_rdy);
        chk(k, "addr", addr[k], m_addr[k]);
        chk(k, "dout", dout[k], m_dout[k]);
        chk(k, "index", idx[k], m_idx[k]);
        chk(k, "byte_count", bcnt[k], m_cnt[k]);
`ifdef IOCTL_LOADER_CSUM_EN
        chk(k, "checksum", csum[k], m_cs[k]);
`endif
        if (wr[k] === 1'b1) begin
            if (nwr[k] < 300) begin
                lg_addr[k][nwr[k]] = addr[k];
                lg_dout[k][nwr[k]] = dout[k];
            end
            if (last_wr[k] >= 0 && cyc - last_wr[k] < min_gap[k])
                min_gap[k] = cyc - last_wr[k];
            last_wr[k] = cyc;
            nwr[k]++;
        end
        if (done[k] === 1'b1) begin
            ndone[k]++;
            done_cyc[k] = cyc;
        end
        if (!reset_n) begin
            m_busy[k] = 0; m_last[k] = 0; rdy_at[k] = 0;
            wr_at[k] = -1; done_at[k] = -1; nxt[k] = '0;
            m_addr[k] = '0; m_dout[k] = '0; m_idx[k] = '0;
            m_cnt[k] = '0; m_cs[k] = '0;
        end else begin
            if (e_wr) begin
                m_cnt[k] = m_cnt[k] + 25'd1;
                m_cs[k]  = m_cs[k] + m_dout[k];
            end
            if (!m_busy[k] && start[k]) begin
                m_busy[k] = 1; m_last[k] = 0; m_idx[k] = index_in[k];
                m_cnt[k] = '0; m_cs[k] = '0; nxt[k] = '0;
                rdy_at[k] = cyc + 2;
            end else if (e_rdy && s_valid[k]) begin
                p_addr[k] = nxt[k];
                nxt[k]    = nxt[k] + 25'd1;
                p_dout[k] = s_data[k];
                wr_at[k]  = cyc + 1;
                rdy_at[k] = cyc + 2 + g;
                if (s_last[k]) begin
                    m_last[k]  = 1;
                    done_at[k] = cyc + 3 + g;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_last[k] = 0; rdy_at[k] = 0;
            wr_at[k] = -1; done_at[k] = -1; nxt[k] = '0;
            m_addr[k] = '0; m_dout[k] = '0; m_idx[k] = '0;
            m_cnt[k] = '0; m_cs[k] = '0; p_addr[k] = '0; p_dout[k] = '0;
            ndone[k] = 0; done_cyc[k] = 0;
            clr_log(k);
        end
        @(posedge clk);
        cyc = 1;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) model_cycle(k);
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int k, input logic [7:0] ix);
        start[k] = 1'b1;
        index_in[k] = ix;
        step;
        start[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [7:0] d,
                        input bit last, input int bub);
        bit acc;
        int n;
        repeat (bub) step;
        s_valid[k] = 1'b1;
        s_data[k]  = d;
        s_last[k]  = last;
        acc = 0;
        n = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = s_ready[k];
            step;
            n++;
        end
        s_valid[k] = 1'b0;
        s_last[k]  = 1'b0;
        if (!acc) chk(k, "send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input int k);
        int d0, n;
        d0 = ndone[k];
        n = 0;
        while (ndone[k] == d0 && n < 200) begin
            step;
            n++;
        end
        chk(k, "done_seen", 32'(ndone[k] - d0), 32'd1);
    endtask

    initial begin
        int n0, errs, d0;
        reset_n = 1'b0;
        start = '0; s_valid = '0; s_last = '0; ioctl_wait = '0;
        for (int k = 0; k < 2; k++) begin
            index_in[k] = '0;
            s_data[k] = '0;
        end
        repeat (3) step;
        reset_n = 1'b1;
        step;

        // Three bytes, no write gap.
        clr_log(0);
        do_start(0, 8'd1);
        send(0, 8'h41, 0, 0);
        send(0, 8'h54, 0, 0);
        send(0, 8'h41, 1, 0);
        wait_done(0);
        chk(0, "t1_nwr", nwr[0], 3);
        chk(0, "t1_a0", lg_addr[0][0], 0);
        chk(0, "t1_a1", lg_addr[0][1], 1);
        chk(0, "t1_a2", lg_addr[0][2], 2);
        chk(0, "t1_d0", lg_dout[0][0], 32'h41);
        chk(0, "t1_d1", lg_dout[0][1], 32'h54);
        chk(0, "t1_d2", lg_dout[0][2], 32'h41);
        chk(0, "t1_fall", done_cyc[0] - last_wr[0], 2);
        chk(0, "t1_count", bcnt[0], 3);
        chk(0, "t1_addr", addr[0], 2);
        chk(0, "t1_index", idx[0], 1);
        chk(0, "t1_dl", dl[0], 0);

        // Back-pressure for five cycles in the middle of an image.
        clr_log(0);
        do_start(0, 8'd2);
        send(0, 8'h10, 0, 0);
        ioctl_wait[0] = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0] = 8'h20;
        repeat (5) begin
            @(negedge clk);
            chk(0, "t2_wait_rdy", s_ready[0], 0);
            chk(0, "t2_wait_dl", dl[0], 1);
            step;
        end
        chk(0, "t2_no_wr", nwr[0], 1);
        ioctl_wait[0] = 1'b0;
        send(0, 8'h20, 0, 0);
        send(0, 8'h30, 1, 0);
        wait_done(0);
        chk(0, "t2_nwr", nwr[0], 3);
        chk(0, "t2_a1", lg_addr[0][1], 1);
        chk(0, "t2_d1", lg_dout[0][1], 32'h20);
        chk(0, "t2_addr", addr[0], 2);
        chk(0, "t2_dout", dout[0], 32'h30);

        // 256 bytes with bubbles, gap 3, and a start that must be ignored.
        clr_log(1);
        do_start(1, 8'd0);
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                do_start(1, 8'd5);
                chk(1, "t3_idx_hold", idx[1], 0);
            end
            send(1, 8'(i * 7 + 3), i == 255, i % 8);
        end
        wait_done(1);
        chk(1, "t3_nwr", nwr[1], 256);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (lg_addr[1][i] != 25'(i) || lg_dout[1][i] != 8'(i * 7 + 3))
                errs++;
        chk(1, "t3_contig", errs, 0);
        chk(1, "t3_min_gap", min_gap[1], 5);
        chk(1, "t3_count", bcnt[1], 256);
        chk(1, "t3_addr", addr[1], 255);
        chk(1, "t3_index", idx[1], 0);

        // Idle start takes the new index; reset after ten writes.
        do_start(1, 8'd5);
        chk(1, "t4_index", idx[1], 5);
        for (int i = 0; i < 10; i++) send(1, 8'(8'h80 + i), 0, 0);
        d0 = ndone[1];
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        chk(1, "t5_dl", dl[1], 0);
        chk(1, "t5_busy", busy[1], 0);
        chk(1, "t5_addr", addr[1], 0);
        chk(1, "t5_dout", dout[1], 0);
        chk(1, "t5_index", idx[1], 0);
        chk(1, "t5_count", bcnt[1], 0);
        repeat (5) step;
        chk(1, "t5_no_done", ndone[1] - d0, 0);

        clr_log(1);
        do_start(1, 8'd9);
        send(1, 8'hFF, 0, 0);
        send(1, 8'h02, 1, 2);
        wait_done(1);
        chk(1, "t6_a0", lg_addr[1][0], 0);
        chk(1, "t6_nwr", nwr[1], 2);
        chk(1, "t6_count", bcnt[1], 2);
        chk(1, "t6_index", idx[1], 9);
`ifdef IOCTL_LOADER_CSUM_EN
        chk(1, "t6_csum", csum[1], 8'h01);
`endif
        repeat (3) step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
